// File: rtl/rom_sequencer.sv
// Instruction-ROM address sequencer: increment/jump, call/return stack, one hardware loop level.
// Optional macro ROM_SEQ_BOUNDS_CHECK_EN turns address carry/borrow into a sticky range error.
module rom_sequencer #(
  parameter int ROM_DEPTH   = 256,
  parameter int JMP_WIDTH   = 8,
  parameter int STACK_DEPTH = 4,
  parameter int LOOP_WIDTH  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_start_i,
  input  logic [31:0]           start_addr_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [2:0]            cmd_op_i,
  input  logic [JMP_WIDTH-1:0]  cmd_arg_i,
  output logic [31:0]           rom_addr_o,
  output logic                  rom_addr_valid_o,
  output logic                  halted_o,
  output logic                  stack_err_o,
  output logic                  range_err_o,
  output logic [LOOP_WIDTH-1:0] loop_cnt_o
);
  // state   | meaning
  // IDLE    | after reset, waiting for load_start_i
  // RUN     | address valid, commands accepted
  // HALT    | HALT command executed, address held
  // ERR     | stack or range error, address held
  localparam int ADDR_WIDTH = $clog2(ROM_DEPTH);
  localparam int SP_W       = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W      = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_HALT = 2'd2, ST_ERR = 2'd3;
  localparam logic [2:0] OP_NEXT = 3'd0, OP_JMP_UP = 3'd1, OP_JMP_DN = 3'd2, OP_CALL = 3'd3,
                         OP_RET = 3'd4, OP_LOOP_SET = 3'd5, OP_LOOP_END = 3'd6, OP_HALT = 3'd7;

`ifdef ROM_SEQ_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, loop_start_q, loop_start_d, arg_a;
  logic [SP_W-1:0]       sp_q, sp_d, sp_dec;
  logic [LOOP_WIDTH-1:0] loop_cnt_q, loop_cnt_d;
  logic                  stack_err_q, stack_err_d, range_err_q, range_err_d;
  logic [ADDR_WIDTH-1:0] stack_mem [STACK_DEPTH];
  logic [ADDR_WIDTH:0]   inc_w, add_w, sub_w;
  logic                  cmd_accept, push_en, stack_full, stack_empty, range_hit;
  logic                  unused_start_bits;

  generate
    if (JMP_WIDTH >= ADDR_WIDTH) begin : g_arg_trunc
      assign arg_a = cmd_arg_i[ADDR_WIDTH-1:0];
    end else begin : g_arg_zext
      assign arg_a = {{(ADDR_WIDTH-JMP_WIDTH){1'b0}}, cmd_arg_i};
    end
  endgenerate

  assign unused_start_bits = ^start_addr_i[31:ADDR_WIDTH];

  // Extra MSB holds the carry/borrow used by the bounds check.
  assign inc_w  = {1'b0, addr_q} + (ADDR_WIDTH+1)'(1);
  assign add_w  = {1'b0, addr_q} + {1'b0, arg_a};
  assign sub_w  = {1'b0, addr_q} - {1'b0, arg_a};

  assign stack_full  = (sp_q == SP_W'(STACK_DEPTH));
  assign stack_empty = (sp_q == '0);
  assign sp_dec      = sp_q - SP_W'(1);

  assign cmd_ready_o = (state_q == ST_RUN) && !load_start_i;
  assign cmd_accept  = cmd_ready_o && cmd_valid_i;

  always_comb begin
    range_hit = 1'b0;
    case (cmd_op_i)
      OP_NEXT, OP_LOOP_SET: range_hit = inc_w[ADDR_WIDTH];
      OP_JMP_UP:            range_hit = add_w[ADDR_WIDTH];
      OP_JMP_DN:            range_hit = sub_w[ADDR_WIDTH];
      OP_LOOP_END:          range_hit = (loop_cnt_q == '0) && inc_w[ADDR_WIDTH];
      default:              range_hit = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    sp_d         = sp_q;
    loop_cnt_d   = loop_cnt_q;
    loop_start_d = loop_start_q;
    stack_err_d  = stack_err_q;
    range_err_d  = range_err_q;
    push_en      = 1'b0;
    if (load_start_i) begin
      state_d     = ST_RUN;
      addr_d      = start_addr_i[ADDR_WIDTH-1:0];
      sp_d        = '0;
      loop_cnt_d  = '0;
      stack_err_d = 1'b0;
      range_err_d = 1'b0;
    end else if (cmd_accept) begin
      if (BOUNDS_EN && range_hit) begin
        state_d     = ST_ERR;
        range_err_d = 1'b1;
      end else begin
        case (cmd_op_i)
          OP_NEXT:   addr_d = inc_w[ADDR_WIDTH-1:0];
          OP_JMP_UP: addr_d = add_w[ADDR_WIDTH-1:0];
          OP_JMP_DN: addr_d = sub_w[ADDR_WIDTH-1:0];
          OP_CALL: begin
            if (stack_full) begin
              stack_err_d = 1'b1;
              state_d     = ST_ERR;
            end else begin
              push_en = 1'b1;
              sp_d    = sp_q + SP_W'(1);
              addr_d  = arg_a;
            end
          end
          OP_RET: begin
            if (stack_empty) begin
              stack_err_d = 1'b1;
              state_d     = ST_ERR;
            end else begin
              sp_d   = sp_dec;
              addr_d = stack_mem[sp_dec[IDX_W-1:0]];
            end
          end
          OP_LOOP_SET: begin
            loop_cnt_d   = cmd_arg_i[LOOP_WIDTH-1:0];
            loop_start_d = inc_w[ADDR_WIDTH-1:0];
            addr_d       = inc_w[ADDR_WIDTH-1:0];
          end
          OP_LOOP_END: begin
            if (loop_cnt_q != '0) begin
              loop_cnt_d = loop_cnt_q - LOOP_WIDTH'(1);
              addr_d     = loop_start_q;
            end else begin
              addr_d = inc_w[ADDR_WIDTH-1:0];
            end
          end
          OP_HALT:  state_d = ST_HALT;
          default:  state_d = state_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      sp_q         <= '0;
      loop_cnt_q   <= '0;
      loop_start_q <= '0;
      stack_err_q  <= 1'b0;
      range_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      sp_q         <= sp_d;
      loop_cnt_q   <= loop_cnt_d;
      loop_start_q <= loop_start_d;
      stack_err_q  <= stack_err_d;
      range_err_q  <= range_err_d;
    end
  end

  // Stack contents need no reset; the stack pointer alone defines validity.
  always_ff @(posedge clk_i) begin
    if (push_en) stack_mem[sp_q[IDX_W-1:0]] <= inc_w[ADDR_WIDTH-1:0];
  end

  assign rom_addr_o       = {{(32-ADDR_WIDTH){1'b0}}, addr_q};
  assign rom_addr_valid_o = (state_q == ST_RUN);
  assign halted_o         = (state_q == ST_HALT);
  assign stack_err_o      = stack_err_q;
  assign range_err_o      = range_err_q;
  assign loop_cnt_o       = loop_cnt_q;
endmodule

// File: tb/tb_rom_sequencer.sv
// Directed bench for rom_sequencer: expected outputs queued per step, compared after each clock edge.
module tb_rom_sequencer;
  logic        clk_i = 1'b0;
  logic        rst_i, load_start_i, cmd_valid_i, cmd_ready_o;
  logic [31:0] start_addr_i, rom_addr_o;
  logic [2:0]  cmd_op_i;
  logic [7:0]  cmd_arg_i, loop_cnt_o;
  logic        rom_addr_valid_o, halted_o, stack_err_o, range_err_o;

  localparam logic [2:0] OP_NEXT = 3'd0, OP_JMP_UP = 3'd1, OP_JMP_DN = 3'd2, OP_CALL = 3'd3,
                         OP_RET = 3'd4, OP_LOOP_SET = 3'd5, OP_LOOP_END = 3'd6, OP_HALT = 3'd7;
`ifdef ROM_SEQ_BOUNDS_CHECK_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] addr;
    logic        valid, halted, serr, rerr;
    logic [7:0]  loop;
  } obs_t;

  obs_t sb[$];
  int   vectors = 0;
  int   errors  = 0;

  rom_sequencer dut (
    .clk_i(clk_i), .rst_i(rst_i), .load_start_i(load_start_i), .start_addr_i(start_addr_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i), .cmd_arg_i(cmd_arg_i),
    .rom_addr_o(rom_addr_o), .rom_addr_valid_o(rom_addr_valid_o), .halted_o(halted_o),
    .stack_err_o(stack_err_o), .range_err_o(range_err_o), .loop_cnt_o(loop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic obs_t mk(logic [31:0] a, logic v, logic h, logic se, logic re, logic [7:0] lp);
    obs_t o;
    o.addr = a; o.valid = v; o.halted = h; o.serr = se; o.rerr = re; o.loop = lp;
    return o;
  endfunction

  task automatic check_ready(input string tag, input logic exp);
    vectors++;
    assert (cmd_ready_o === exp) else begin
      errors++;
      $error("FAIL %s ready: got %b want %b", tag, cmd_ready_o, exp);
    end
  endtask

  task automatic check_sb(input string tag);
    obs_t o, e;
    o = mk(rom_addr_o, rom_addr_valid_o, halted_o, stack_err_o, range_err_o, loop_cnt_o);
    vectors++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL %s scoreboard empty: got %h", tag, o);
    end else begin
      e = sb.pop_front();
      assert (o === e) else begin
        errors++;
        $error("FAIL %s: got addr=%h v=%b h=%b se=%b re=%b lp=%h want addr=%h v=%b h=%b se=%b re=%b lp=%h",
               tag, o.addr, o.valid, o.halted, o.serr, o.rerr, o.loop,
               e.addr, e.valid, e.halted, e.serr, e.rerr, e.loop);
      end
    end
  endtask

  task automatic step(input string tag, input logic ld, input logic [31:0] sa, input logic v,
                      input logic [2:0] op, input logic [7:0] arg, input logic exp_rdy, input obs_t e);
    load_start_i = ld; start_addr_i = sa; cmd_valid_i = v; cmd_op_i = op; cmd_arg_i = arg;
    #1;
    check_ready(tag, exp_rdy);
    sb.push_back(e);
    @(posedge clk_i); #1;
    check_sb(tag);
  endtask

  task automatic cmd(input string tag, input logic [2:0] op, input logic [7:0] arg, input obs_t e);
    step(tag, 1'b0, 32'h0, 1'b1, op, arg, 1'b1, e);
  endtask

  task automatic load(input string tag, input logic [31:0] sa, input obs_t e);
    step(tag, 1'b1, sa, 1'b0, OP_NEXT, 8'h0, 1'b0, e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1; load_start_i = 1'b0; start_addr_i = '0; cmd_valid_i = 1'b0;
    cmd_op_i = OP_NEXT; cmd_arg_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    sb.push_back(mk(0, 0, 0, 0, 0, 0));
    check_sb("reset");
    check_ready("reset", 1'b0);
    @(negedge clk_i) rst_i = 1'b0;

    step("idle_no_accept", 1'b0, 32'h0, 1'b1, OP_NEXT, 8'h0, 1'b0, mk(0, 0, 0, 0, 0, 0));
    step("load_10_with_cmd", 1'b1, 32'h10, 1'b1, OP_NEXT, 8'h0, 1'b0, mk(32'h10, 1, 0, 0, 0, 0));
    cmd("next_11", OP_NEXT, 8'h0, mk(32'h11, 1, 0, 0, 0, 0));
    cmd("next_12", OP_NEXT, 8'h0, mk(32'h12, 1, 0, 0, 0, 0));
    cmd("next_13", OP_NEXT, 8'h0, mk(32'h13, 1, 0, 0, 0, 0));

    load("load_20", 32'h20, mk(32'h20, 1, 0, 0, 0, 0));
    cmd("jmp_up_25", OP_JMP_UP, 8'h05, mk(32'h25, 1, 0, 0, 0, 0));
    cmd("jmp_dn_30", OP_JMP_DN, 8'h30, mk(BC ? 32'h25 : 32'hF5, !BC, 0, 0, BC, 0));
    step("after_jmp_dn", 1'b0, 32'h0, 1'b0, OP_NEXT, 8'h0, !BC,
         mk(BC ? 32'h25 : 32'hF5, !BC, 0, 0, BC, 0));
    load("load_ff", 32'hFF, mk(32'hFF, 1, 0, 0, 0, 0));
    cmd("next_wrap", OP_NEXT, 8'h0, mk(BC ? 32'hFF : 32'h00, !BC, 0, 0, BC, 0));

    load("load_08", 32'h08, mk(32'h08, 1, 0, 0, 0, 0));
    cmd("call_40", OP_CALL, 8'h40, mk(32'h40, 1, 0, 0, 0, 0));
    cmd("call_80", OP_CALL, 8'h80, mk(32'h80, 1, 0, 0, 0, 0));
    cmd("ret_41", OP_RET, 8'h0, mk(32'h41, 1, 0, 0, 0, 0));
    cmd("ret_09", OP_RET, 8'h0, mk(32'h09, 1, 0, 0, 0, 0));
    cmd("ret_empty", OP_RET, 8'h0, mk(32'h09, 0, 0, 1, 0, 0));
    step("err_no_accept", 1'b0, 32'h0, 1'b1, OP_NEXT, 8'h0, 1'b0, mk(32'h09, 0, 0, 1, 0, 0));

    load("load_00", 32'h00, mk(32'h00, 1, 0, 0, 0, 0));
    for (int i = 1; i <= 4; i++)
      cmd("call_nested", OP_CALL, 8'(i * 16), mk(32'(i * 16), 1, 0, 0, 0, 0));
    cmd("call_overflow", OP_CALL, 8'h50, mk(32'h40, 0, 0, 1, 0, 0));

    load("load_30_clear", 32'h30, mk(32'h30, 1, 0, 0, 0, 0));
    cmd("loop_set", OP_LOOP_SET, 8'h02, mk(32'h31, 1, 0, 0, 0, 8'd2));
    for (int k = 0; k < 3; k++) begin
      cmd("loop_body_32", OP_NEXT, 8'h0, mk(32'h32, 1, 0, 0, 0, 8'(2 - k)));
      cmd("loop_body_33", OP_NEXT, 8'h0, mk(32'h33, 1, 0, 0, 0, 8'(2 - k)));
      cmd("loop_end", OP_LOOP_END, 8'h0,
          mk((k < 2) ? 32'h31 : 32'h34, 1, 0, 0, 0, (k < 2) ? 8'(1 - k) : 8'd0));
    end

    cmd("halt", OP_HALT, 8'h0, mk(32'h34, 0, 1, 0, 0, 0));
    step("halt_no_accept", 1'b0, 32'h0, 1'b1, OP_JMP_UP, 8'h10, 1'b0, mk(32'h34, 0, 1, 0, 0, 0));
    step("load_beats_cmd", 1'b1, 32'h50, 1'b1, OP_JMP_UP, 8'h10, 1'b0, mk(32'h50, 1, 0, 0, 0, 0));
    cmd("next_51", OP_NEXT, 8'h0, mk(32'h51, 1, 0, 0, 0, 0));
    cmd("loop_set_7", OP_LOOP_SET, 8'h07, mk(32'h52, 1, 0, 0, 0, 8'd7));

    load_start_i = 1'b0; cmd_valid_i = 1'b1; cmd_op_i = OP_NEXT;
    #3 rst_i = 1'b1;
    #1;
    sb.push_back(mk(0, 0, 0, 0, 0, 0));
    check_sb("async_reset");
    check_ready("async_reset", 1'b0);
    @(negedge clk_i) rst_i = 1'b0;
    step("post_reset_idle", 1'b0, 32'h0, 1'b1, OP_NEXT, 8'h0, 1'b0, mk(0, 0, 0, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
